// File: rtl/cnt_en_ctrl_pkg.sv
// Shared definitions for the decade-counter enable controller: run-state
// encodings and default timing constants.
package cnt_en_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    localparam int DIV_DEF    = 10;
    localparam int DB_CNT_DEF = 4;

endpackage

// File: rtl/cnt_en_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce filter and a one-cycle
// press pulse on each debounced rising edge.
module cnt_en_debounce
    import cnt_en_ctrl_pkg::*;
#(
    parameter int DB_CNT = DB_CNT_DEF,
    parameter int DB_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic press
);

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            press    <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= din;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            // any agreeing cycle restarts the qualification window
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_CNT - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/cnt_en_ctrl.sv
// Turns start/stop and single-step buttons into one-clock EN pulses for the
// decade counter: free-running via a prescaler, or one pulse per step press.
module cnt_en_ctrl
    import cnt_en_ctrl_pkg::*;
#(
    parameter int DIV    = DIV_DEF,
    parameter int DIV_W  = 4,
    parameter int DB_CNT = DB_CNT_DEF,
    parameter int DB_W   = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic START_STOP,
    input  logic STEP_IN,
    output logic EN,
    output logic RUN
);

    run_state_e       state, state_n;
    logic [DIV_W-1:0] presc, presc_n;
    logic             en_n;
    logic             ss_press;
    logic             step_press;

    cnt_en_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_ss (
        .clk   (CLK),
        .rst   (RESET),
        .din   (START_STOP),
        .press (ss_press)
    );

    cnt_en_debounce #(.DB_CNT(DB_CNT), .DB_W(DB_W)) u_db_step (
        .clk   (CLK),
        .rst   (RESET),
        .din   (STEP_IN),
        .press (step_press)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            presc <= '0;
            EN    <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            EN    <= en_n;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        en_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                presc_n = '0;
                // start/stop has priority; a coincident step is dropped
                if (ss_press) state_n = ST_RUN;
                else if (step_press) en_n = 1'b1;
            end
            ST_RUN: begin
                if (ss_press) begin
                    // stopping on the wrap edge suppresses that final pulse
                    state_n = ST_IDLE;
                    presc_n = '0;
                end else if (presc == DIV_W'(DIV - 1)) begin
                    en_n    = 1'b1;
                    presc_n = '0;
                end else begin
                    presc_n = presc + DIV_W'(1);
                end
            end
        endcase
    end

    assign RUN = (state == ST_RUN);

endmodule

// File: tb/tb_cnt_en_ctrl.sv
// Scoreboard bench for cnt_en_ctrl: stimulus queues expected EN/RUN edge
// numbers, a negedge monitor matches them against what the DUT produces.
module tb_cnt_en_ctrl;

    logic CLK = 1'b0;
    logic RESET;
    logic START_STOP;
    logic STEP_IN;
    logic EN;
    logic RUN;

    typedef struct {
        int   cyc;
        logic val;
    } run_ev_t;

    int      cyc   = 0;
    int      total = 0;
    int      bad   = 0;
    bit      mon_on = 1'b0;
    logic    run_prev = 1'b0;
    int      en_q[$];
    run_ev_t run_q[$];
    run_ev_t mev;

    cnt_en_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START_STOP (START_STOP),
        .STEP_IN    (STEP_IN),
        .EN         (EN),
        .RUN        (RUN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // park on the negedge just before edge e so new inputs are sampled at e
    task automatic at(input int e);
        while (cyc < e - 1) @(negedge CLK);
    endtask

    task automatic exp_run(input int e, input logic v);
        run_ev_t ev;
        ev.cyc = e;
        ev.val = v;
        run_q.push_back(ev);
    endtask

    // monitor: after edge n, cyc == n
    always @(negedge CLK) begin
        if (mon_on) begin
            while (en_q.size() > 0 && en_q[0] < cyc)
                chk("en_missing", cyc, en_q.pop_front());
            while (run_q.size() > 0 && run_q[0].cyc < cyc) begin
                mev = run_q.pop_front();
                chk("run_missing", cyc, mev.cyc);
            end
            if (EN !== 1'b0) begin
                if (en_q.size() == 0) chk("en_unexpected", cyc, -1);
                else                  chk("en_edge", cyc, en_q.pop_front());
            end
            if (RUN !== run_prev) begin
                if (run_q.size() == 0) begin
                    chk("run_unexpected", cyc, -1);
                end else begin
                    mev = run_q.pop_front();
                    chk("run_edge", cyc, mev.cyc);
                    chk("run_val", int'(RUN), int'(mev.val));
                end
                run_prev = RUN;
            end
        end
    end

    initial begin
        RESET      = 1'b1;
        START_STOP = 1'b1;
        STEP_IN    = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_en", int'(EN), 0);
            chk("rst_run", int'(RUN), 0);
        end
        RESET      = 1'b0;
        START_STOP = 1'b0;
        STEP_IN    = 1'b0;
        run_prev   = 1'b0;
        mon_on     = 1'b1;

        // clean start at edge 20, step press while running, stop at prescaler=9
        at(20);  START_STOP = 1'b1;
        exp_run(27, 1'b1);
        en_q.push_back(37); en_q.push_back(47);
        en_q.push_back(57); en_q.push_back(67);
        at(40);  START_STOP = 1'b0;
        at(50);  STEP_IN = 1'b1;
        at(58);  STEP_IN = 1'b0;
        at(70);  START_STOP = 1'b1;
        exp_run(77, 1'b0);
        at(78);  START_STOP = 1'b0;

        // step glitch of 3 cycles, then a 6-cycle step press in IDLE
        at(100); STEP_IN = 1'b1;
        at(103); STEP_IN = 1'b0;
        at(120); STEP_IN = 1'b1;
        en_q.push_back(127);
        at(126); STEP_IN = 1'b0;

        // bouncing start: 1,0,1,0 then steady high from edge 144
        at(140); START_STOP = 1'b1;
        at(141); START_STOP = 1'b0;
        at(142); START_STOP = 1'b1;
        at(143); START_STOP = 1'b0;
        at(144); START_STOP = 1'b1;
        exp_run(151, 1'b1);
        en_q.push_back(161); en_q.push_back(171); en_q.push_back(181);
        at(160); START_STOP = 1'b0;

        // stop press interrupted by reset mid-debounce
        at(180); START_STOP = 1'b1;
        at(183); RESET = 1'b1; START_STOP = 1'b0;
        exp_run(183, 1'b0);
        @(negedge CLK);
        chk("midrst_en", int'(EN), 0);
        chk("midrst_run", int'(RUN), 0);
        at(185); RESET = 1'b0;

        // simultaneous start/stop and step in IDLE: run wins, no step pulse
        at(200); START_STOP = 1'b1; STEP_IN = 1'b1;
        exp_run(207, 1'b1);
        en_q.push_back(217); en_q.push_back(227);
        at(208); START_STOP = 1'b0; STEP_IN = 1'b0;

        at(233);
        chk("en_q_left", en_q.size(), 0);
        chk("run_q_left", run_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
